// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle synchronous imem and presents {instr, pc, pc+4} to decode.
// Issue-to-output latency is 2 edges. While decode stalls, the in-flight word is replayed and every register holds.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    logic [31:0] r_pc;
    logic [31:0] r_rsp_pc;
    logic        r_rsp_pending;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;

    logic [31:0] w_redirect_pc;
    logic        w_accept;
    logic        w_stall;
    logic        w_issue;

    assign w_redirect_pc = redirect_pc & ~32'd3;
    assign w_accept      = r_rsp_pending && (!r_if_valid || if_ready);
    assign w_stall       = r_rsp_pending && !w_accept;
    assign w_issue       = fetch_en && (!r_rsp_pending || w_accept);

    // The memory has no read enable, so a stall re-presents the owed word's address.
    always_comb begin
        if (redirect_valid) begin
            imem_addr = w_redirect_pc;
        end else if (w_stall) begin
            imem_addr = r_rsp_pc;
        end else begin
            imem_addr = r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_rsp_pending <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= NOP_INSTR;
            r_if_pc       <= RESET_PC;
        end else if (redirect_valid) begin
            r_if_valid <= 1'b0;
            if (fetch_en) begin
                r_rsp_pc      <= w_redirect_pc;
                r_pc          <= w_redirect_pc + 32'd4;
                r_rsp_pending <= 1'b1;
            end else begin
                r_pc          <= w_redirect_pc;
                r_rsp_pending <= 1'b0;
            end
        end else if (!w_stall) begin
            if (w_accept) begin
                r_if_instr <= imem_rd;
                r_if_pc    <= r_rsp_pc;
                r_if_valid <= 1'b1;
            end else if (if_ready) begin
                r_if_valid <= 1'b0;
            end
            if (w_issue) begin
                r_rsp_pc      <= r_pc;
                r_pc          <= r_pc + 32'd4;
                r_rsp_pending <= 1'b1;
            end else begin
                r_rsp_pending <= 1'b0;
            end
        end
    end

    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: stream-level scoreboard on the main instance plus directed checks,
// and a second instance started at 0xFFFF_FFFC for PC wrap-around.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    logic        fetch_en2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rd2;
    logic        if_valid2;
    logic        if_ready2;
    logic [31:0] if_instr2;
    logic [31:0] if_pc2;
    logic [31:0] if_pc_plus42;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rd(imem_rd),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .imem_addr(imem_addr2), .imem_rd(imem_rd2),
        .if_valid(if_valid2), .if_ready(if_ready2), .if_instr(if_instr2),
        .if_pc(if_pc2), .if_pc_plus4(if_pc_plus42)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h00a0_0113;
            32'h0000_0008: mem_word = 32'h0020_81b3;
            default:       mem_word = 32'h0BAD_0000 | {16'h0, addr[15:0]};
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memories.
    always @(posedge clk) begin
        imem_rd  <= mem_word(imem_addr);
        imem_rd2 <= mem_word(imem_addr2);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream model: accepted instructions form a consecutive PC sequence restarted by redirect/reset.
    logic [31:0] exp_pc = 32'h0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc, prev_instr;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc    = 32'h0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("sb_hold_valid", {31'h0, if_valid}, 32'h1);
                chk("sb_hold_pc", if_pc, prev_pc);
                chk("sb_hold_instr", if_instr, prev_instr);
            end
            if (if_valid) chk("sb_plus4", if_pc_plus4, if_pc + 32'd4);
            if (redirect_valid) chk("sb_redir_addr", imem_addr, redirect_pc & ~32'd3);
            if (if_valid && if_ready) begin
                chk("sb_seq_pc", if_pc, exp_pc);
                chk("sb_seq_instr", if_instr, mem_word(if_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
            prev_hold  = if_valid && !if_ready && !redirect_valid;
            prev_pc    = if_pc;
            prev_instr = if_instr;
        end
    end

    initial begin
        rst_n = 1'b1; fetch_en = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        fetch_en2 = 1'b1; if_ready2 = 1'b1; redirect_valid2 = 1'b0; redirect_pc2 = 32'h0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h0000_0013);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wrap_addr", imem_addr2, 32'hFFFF_FFFC);

        tick(); rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
        @(negedge clk); chk("c0_valid", {31'h0, if_valid}, 32'h0);
        tick(); @(negedge clk); chk("c1_valid", {31'h0, if_valid}, 32'h0);
        tick(); @(negedge clk);
        chk("c2_valid", {31'h0, if_valid}, 32'h1);
        chk("c2_pc", if_pc, 32'h0);
        chk("c2_instr", if_instr, 32'h0050_0093);
        chk("c2_plus4", if_pc_plus4, 32'h4);
        chk("wrap_pc0", if_pc2, 32'hFFFF_FFFC);
        chk("wrap_plus4", if_pc_plus42, 32'h0);

        // Decode stalls for three cycles with pc 0x4 held; the owed word 0x8 is replayed.
        tick(); if_ready = 1'b0;
        @(negedge clk);
        chk("wrap_pc1", if_pc2, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk("bp_valid", {31'h0, if_valid}, 32'h1);
            chk("bp_pc", if_pc, 32'h4);
            chk("bp_instr", if_instr, 32'h00a0_0113);
            chk("bp_addr", imem_addr, 32'h8);
        end
        tick(); if_ready = 1'b1;
        @(negedge clk); chk("c6_pc", if_pc, 32'h4);

        tick(); redirect_valid = 1'b1; redirect_pc = 32'h20;
        @(negedge clk);
        chk("c7_pc", if_pc, 32'h8);
        chk("c7_instr", if_instr, 32'h0020_81b3);
        chk("c7_addr", imem_addr, 32'h20);
        tick(); redirect_valid = 1'b0;
        @(negedge clk); chk("c8_valid", {31'h0, if_valid}, 32'h0);
        tick(); @(negedge clk);
        chk("c9_valid", {31'h0, if_valid}, 32'h1);
        chk("c9_pc", if_pc, 32'h20);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h23;
        @(negedge clk);
        chk("c10_pc", if_pc, 32'h24);
        chk("c10_addr", imem_addr, 32'h20);
        tick(); redirect_valid = 1'b0;
        @(negedge clk); chk("c11_valid", {31'h0, if_valid}, 32'h0);

        // Stop fetching with 0x24 in flight: it is delivered, then nothing more.
        tick(); fetch_en = 1'b0;
        @(negedge clk); chk("c12_pc", if_pc, 32'h20);
        tick(); @(negedge clk);
        chk("c13_valid", {31'h0, if_valid}, 32'h1);
        chk("c13_pc", if_pc, 32'h24);
        tick(); @(negedge clk);
        chk("c14_valid", {31'h0, if_valid}, 32'h0);
        chk("c14_addr", imem_addr, 32'h28);
        tick(); @(negedge clk);
        chk("c15_valid", {31'h0, if_valid}, 32'h0);
        chk("c15_addr", imem_addr, 32'h28);
        tick(); fetch_en = 1'b1;
        @(negedge clk); chk("c16_valid", {31'h0, if_valid}, 32'h0);
        tick(); @(negedge clk); chk("c17_valid", {31'h0, if_valid}, 32'h0);
        tick(); @(negedge clk);
        chk("c18_valid", {31'h0, if_valid}, 32'h1);
        chk("c18_pc", if_pc, 32'h28);
        tick(); @(negedge clk); chk("c19_pc", if_pc, 32'h2C);

        // Asynchronous reset between edges.
        @(posedge clk); #3 rst_n = 1'b0; #1;
        chk("arst_valid", {31'h0, if_valid}, 32'h0);
        chk("arst_instr", if_instr, 32'h0000_0013);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        repeat (2) @(posedge clk);
        tick(); rst_n = 1'b1;
        @(negedge clk); chk("r0_valid", {31'h0, if_valid}, 32'h0);
        tick(); @(negedge clk); chk("r1_valid", {31'h0, if_valid}, 32'h0);
        tick(); @(negedge clk);
        chk("r2_pc", if_pc, 32'h0);
        chk("r2_instr", if_instr, 32'h0050_0093);
        tick(); @(negedge clk); chk("r3_pc", if_pc, 32'h4);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
